// File: rtl/port_link_pkg.sv
// Shared constants for the torus link endpoint: flit width, connector slice
// layout and the port numbering used by the switch.
package port_pkg;
  localparam int DATA_WIDTH = 37;
  localparam int PORT_SIZE  = DATA_WIDTH + 2;
  localparam int VALID_BIT  = DATA_WIDTH;
  localparam int READY_BIT  = DATA_WIDTH + 1;
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] PORT_RIGHT = 2'd0;
  localparam logic [1:0] PORT_DOWN  = 2'd1;
  localparam logic [1:0] PORT_LEFT  = 2'd2;
  localparam logic [1:0] PORT_UP    = 2'd3;

  typedef logic [DATA_WIDTH-1:0] flit_t;
endpackage

// File: rtl/port_link_if.sv
// Local switch-side flit streams of one port_link, plus receive FIFO fill level.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and data is only meaningful while valid is high.
interface port_link_if
  import port_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int CW = $clog2(FIFO_DEPTH) + 1
);
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [CW-1:0] rx_count;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_count
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_count
  );
endinterface

// File: rtl/port_link_fifo.sv
// Small synchronous FIFO with a show-ahead head; pointers wrap naturally and a
// separate count register tells full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/port_link.sv
// Switch-side endpoint for one torus link direction pair: registered TX slot
// toward the neighbour and a receive FIFO feeding the switch.
module port_link #(
  parameter int DATA_WIDTH = port_pkg::DATA_WIDTH,
  parameter int PORT_SIZE  = DATA_WIDTH + 2,
  parameter int FIFO_DEPTH = port_pkg::FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PORT_SIZE-1:0] port_o,
  input  logic [PORT_SIZE-1:0] port_i,
  port_link_if.slave           sw
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int V_BIT = DATA_WIDTH;
  localparam int R_BIT = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  tx_fire;
  logic                  tx_accept;
  logic                  adv_ready;
  logic                  rx_fire;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;
  logic [CW-1:0]         rx_count;
  logic [DATA_WIDTH-1:0] rx_head;

  // The neighbour sees the same out_valid and ready flops, so both ends agree on the fire.
  assign tx_fire     = out_valid & port_i[R_BIT];
  assign sw.tx_ready = ~rst & (~out_valid | tx_fire);
  assign tx_accept   = sw.tx_valid & sw.tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (tx_accept) begin
      out_valid <= 1'b1;
      out_data  <= sw.tx_data;
    end else if (tx_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign adv_ready = ~rst & ~rx_full;
  assign rx_fire   = port_i[V_BIT] & adv_ready;
  assign rx_pop    = sw.rx_valid & sw.rx_ready;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_fire),
    .wdata (port_i[DATA_WIDTH-1:0]),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign sw.rx_valid = ~rst & ~rx_empty;
  assign sw.rx_data  = sw.rx_valid ? rx_head : '0;
  assign sw.rx_count = rx_count;

  // rst only masks local flops here; nothing from port_i reaches port_o.
  assign port_o = rst ? '0 : {adv_ready, out_valid, out_data};
endmodule

// File: tb/tb_port_link.sv
// Two cross-connected port_link endpoints; A streams flits to B while a negedge
// monitor scores B's output against an occupancy/order model.
module tb_port_link;
  import port_pkg::*;

  localparam int DW = DATA_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [PORT_SIZE-1:0] a_port_o;
  logic [PORT_SIZE-1:0] b_port_o;

  port_link_if a_if ();
  port_link_if b_if ();

  port_link u_a (.clk(clk), .rst(rst), .port_o(a_port_o), .port_i(b_port_o), .sw(a_if));
  port_link u_b (.clk(clk), .rst(rst), .port_o(b_port_o), .port_i(a_port_o), .sw(b_if));

  // ---------------- scoreboard state ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [DW-1:0]  send_q[$];
  logic [DW-1:0]  exp_q[$];
  int             tx_stall = 0;
  int             rx_mode  = 0;   // 0 = hold low, 1 = hold high, 2 = random
  int             rx_stall = 0;
  int             occ      = 0;   // flits sitting in B's receive buffer
  bit             held     = 1'b0; // A has a flit waiting on the link
  logic [DW-1:0]  held_data = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    if (send_q.size() > 0 && int'($urandom_range(99)) >= tx_stall) begin
      a_if.tx_valid = 1'b1;
      a_if.tx_data  = send_q[0];
    end else begin
      a_if.tx_valid = 1'b0;
      a_if.tx_data  = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rx_mode)
      0:       b_if.rx_ready = 1'b0;
      1:       b_if.rx_ready = 1'b1;
      default: b_if.rx_ready = (int'($urandom_range(99)) >= rx_stall);
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic b_rdy;
    logic acc;
    logic fire;
    logic pop;
    if (rst) begin
      check("rst_a_port_o", a_port_o, '0);
      check("rst_b_port_o", b_port_o, '0);
      check("rst_a_tx_ready", a_if.tx_ready, 0);
      check("rst_b_rx_valid", b_if.rx_valid, 0);
      check("rst_b_rx_data", b_if.rx_data, '0);
      exp_q.delete();
      occ  = 0;
      held = 1'b0;
    end else begin
      b_rdy = b_port_o[READY_BIT];
      check("b_ready", b_rdy, occ != FIFO_DEPTH);
      check("b_rx_valid", b_if.rx_valid, occ != 0);
      check("b_count", b_if.rx_count, occ);
      check("a_out_valid", a_port_o[VALID_BIT], held);
      if (held) check("a_out_data", a_port_o[DW-1:0], held_data);
      check("a_tx_ready", a_if.tx_ready, !held || b_rdy);
      check("a_rx_valid", a_if.rx_valid, 0);
      acc  = a_if.tx_valid & a_if.tx_ready;
      fire = held & b_rdy;
      pop  = b_if.rx_valid & b_if.rx_ready;
      if (pop) begin
        if (exp_q.size() == 0) check("rx_unexpected", b_if.rx_data, 64'hDEAD);
        else check("rx_data", b_if.rx_data, exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(a_if.tx_data);
        void'(send_q.pop_front());
        held      = 1'b1;
        held_data = a_if.tx_data;
      end else if (fire) begin
        held = 1'b0;
      end
      occ = occ + (fire ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  task automatic wait_drain(string name);
    bit done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (send_q.size() == 0 && exp_q.size() == 0 && !held) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: drain timeout, %0d unsent %0d undelivered", name, send_q.size(), exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t_acc;
    int t_vis;
    logic [63:0] r;
    a_if.rx_ready = 1'b1;
    b_if.tx_valid = 1'b0;
    b_if.tx_data  = '0;

    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", b_port_o[READY_BIT], 1);
    check("post_rst_tx_ready", a_if.tx_ready, 1);

    // back-to-back stream, latency and throughput
    rx_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) send_q.push_back(DW'(i));
    t_acc = -100;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_if.tx_valid && a_if.tx_ready) begin t_acc = cyc; break; end
    end
    t_vis = -1000;
    for (int k = 0; k < 20; k++) begin
      if (b_if.rx_valid) begin t_vis = cyc; break; end
      @(negedge clk);
    end
    check("first_latency", t_vis - t_acc, 2);
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      check("stream_gap", b_if.rx_valid, 1);
    end
    wait_drain("stream");

    // backpressure to full
    rx_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) send_q.push_back(DW'(12'h100 + i));
    repeat (15) @(negedge clk);
    check("bp_ready_low", b_port_o[READY_BIT], 0);
    check("bp_tx_ready", a_if.tx_ready, 0);
    check("bp_held_valid", a_port_o[VALID_BIT], 1);
    check("bp_held_data", a_port_o[DW-1:0], 12'h104);
    check("bp_pending", send_q.size(), 1);
    check("bp_count", b_if.rx_count, 4);

    // one pop from full
    rx_mode = 1;
    @(negedge clk);
    rx_mode = 0;
    @(negedge clk);
    check("pop_full_ready", b_port_o[READY_BIT], 1);
    repeat (6) @(negedge clk);
    check("refill_count", b_if.rx_count, 4);
    check("refill_held_data", a_port_o[DW-1:0], 12'h105);
    check("refill_pending", send_q.size(), 0);
    rx_mode = 1;
    wait_drain("pop_full");

    // simultaneous push and pop at two deep
    rx_mode = 0;
    send_q.push_back(DW'(12'h200));
    send_q.push_back(DW'(12'h201));
    repeat (6) @(negedge clk);
    check("pp_start_count", b_if.rx_count, 2);
    for (int i = 2; i < 12; i++) send_q.push_back(DW'(12'h200 + i));
    @(negedge clk);
    rx_mode = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("pp_steady_count", b_if.rx_count, 2);
    end
    wait_drain("push_pop");

    // reset mid-stream with a held flit and three buffered
    rx_mode = 0;
    for (int i = 0; i < 3; i++) send_q.push_back(DW'(12'h300 + i));
    repeat (8) @(negedge clk);
    check("mid_count", b_if.rx_count, 3);
    send_q.push_back(DW'(12'h3FF));
    t_acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_if.tx_valid && a_if.tx_ready) begin t_acc = 1; break; end
    end
    check("mid_accept_seen", t_acc, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_a_port_o", a_port_o, '0);
    check("mid_rst_b_port_o", b_port_o, '0);
    check("mid_rst_rx_valid", b_if.rx_valid, 0);
    check("mid_rst_tx_ready", a_if.tx_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_post_ready", b_port_o[READY_BIT], 1);
    check("mid_post_tx_ready", a_if.tx_ready, 1);
    rx_mode = 1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale", b_if.rx_valid, 0);
    end

    // payload integrity under random stalls on both sides
    tx_stall = 40;
    rx_stall = 40;
    rx_mode  = 2;
    for (int i = 0; i < 40; i++)
      send_q.push_back((i % 2 == 0) ? DW'(40'h1555555555) : DW'(40'h0AAAAAAAAA));
    wait_drain("alternating");
    for (int i = 0; i < 40; i++) begin
      r = {$urandom(), $urandom()};
      send_q.push_back(r[DW-1:0]);
    end
    wait_drain("random");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
